// File: rtl/beta_hazard_pkg.sv
// Shared types and constants for the Beta pipeline hazard controller.
package beta_hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    IRQ_HOLD = 2'd3
  } hazard_state_t;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd31;

  // Legal range of load-use bubbles; the counter holds the extra cycles only.
  localparam int unsigned LOAD_STALL_MIN = 1;
  localparam int unsigned LOAD_STALL_MAX = 3;
  localparam int unsigned STALL_CNT_W    = 2;

  localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator between the ID sources and the EX load target.
module load_use_detect
  import beta_hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_rb,
  input  logic [REG_W-1:0] ex_rc,
  input  logic             ex_memread,
  output logic             hazard_c
);

  logic ra_match;
  logic rb_match;

  always_comb begin
    ra_match = (ex_rc == id_ra);
    rb_match = id_uses_rb && (ex_rc == id_rb);
    // R31 reads as zero, so a load targeting it never produces a live value.
    hazard_c = ex_memread && (ex_rc != REG_ZERO) && (ra_match || rb_match);
  end

endmodule

// File: rtl/beta_hazard_ctrl.sv
// Pipeline hazard/stall controller for the pipelined Beta core (Mealy controls).
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module beta_hazard_ctrl
  import beta_hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  input  logic             kernel_mode,
  input  logic [REG_W-1:0] id_ra,
  input  logic [REG_W-1:0] id_rb,
  input  logic             id_uses_rb,
  input  logic [REG_W-1:0] ex_rc,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic             irq_take
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  hazard_state_t          state;
  hazard_state_t          state_nxt;
  hazard_state_t          ret_state;
  hazard_state_t          ret_state_nxt;
  logic [STALL_CNT_W-1:0] cnt;
  logic [STALL_CNT_W-1:0] cnt_nxt;
  logic                   hazard_c;
  logic                   mem_wait_c;

  load_use_detect u_load_use_detect (
    .id_ra      (id_ra),
    .id_rb      (id_rb),
    .id_uses_rb (id_uses_rb),
    .ex_rc      (ex_rc),
    .ex_memread (ex_memread),
    .hazard_c   (hazard_c)
  );

  assign mem_wait_c = mem_req && !mem_ready;

  // State, return-state and stall countdown registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      ret_state <= RUN;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_state_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next state and pipeline controls; priority wait > branch > load-use > irq.
  always_comb begin
    state_nxt     = state;
    ret_state_nxt = ret_state;
    cnt_nxt       = cnt;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    memwb_bubble  = 1'b0;
    irq_take      = 1'b0;

    if (!reset) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (mem_wait_c) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_nxt    = MEM_WAIT;
      if (state != MEM_WAIT) begin
        ret_state_nxt = (state == LD_STALL) ? LD_STALL : RUN;
      end
    end else begin
      case (state)
        // Release cycle: memory data lands in MEM/WB, everything upstream holds.
        MEM_WAIT: begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          state_nxt = ret_state;
        end

        LD_STALL: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = RUN;
            cnt_nxt     = '0;
          end else begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (cnt <= STALL_CNT_W'(1)) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - STALL_CNT_W'(1);
            end
          end
        end

        // RUN and IRQ_HOLD share decode; only RUN may accept an interrupt.
        default: begin
          state_nxt = RUN;
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (hazard_c) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt = LD_STALL;
              cnt_nxt   = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
            end
          end else if ((state == RUN) && irq && !kernel_mode) begin
            irq_take   = 1'b1;
            ifid_flush = 1'b1;
            state_nxt  = IRQ_HOLD;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  // Outside reset, ifid_flush is raised only by a branch flush or irq entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en) begin
        stall_cycles <= stall_cycles + PERF_W'(1);
      end
      if (ifid_flush) begin
        flush_count <= flush_count + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_beta_hazard_ctrl.sv
// Directed bench for beta_hazard_ctrl: three instances (1, 2, 3 stall cycles)
// checked each cycle against a behavioural model plus hand-computed literals.
module tb_beta_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       irq;
  logic       kernel_mode;
  logic [4:0] id_ra;
  logic [4:0] id_rb;
  logic       id_uses_rb;
  logic [4:0] ex_rc;
  logic       ex_memread;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  // Output bundle per instance: {pc,ifid,idex,exmem enables, ifid_flush, idex_bubble, memwb_bubble, irq_take}
  wire [7:0] o1;
  wire [7:0] o2;
  wire [7:0] o3;
`ifdef HAZARD_PERF_EN
  wire [31:0] sc [3];
  wire [31:0] fc [3];
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  beta_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .irq(irq), .kernel_mode(kernel_mode),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb), .ex_rc(ex_rc),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(o1[7]), .ifid_en(o1[6]), .idex_en(o1[5]), .exmem_en(o1[4]),
    .ifid_flush(o1[3]), .idex_bubble(o1[2]), .memwb_bubble(o1[1]), .irq_take(o1[0])
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc[0]), .flush_count(fc[0])
`endif
  );

  beta_hazard_ctrl #(.LOAD_STALL_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .irq(irq), .kernel_mode(kernel_mode),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb), .ex_rc(ex_rc),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(o2[7]), .ifid_en(o2[6]), .idex_en(o2[5]), .exmem_en(o2[4]),
    .ifid_flush(o2[3]), .idex_bubble(o2[2]), .memwb_bubble(o2[1]), .irq_take(o2[0])
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc[1]), .flush_count(fc[1])
`endif
  );

  beta_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .irq(irq), .kernel_mode(kernel_mode),
    .id_ra(id_ra), .id_rb(id_rb), .id_uses_rb(id_uses_rb), .ex_rc(ex_rc),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(o3[7]), .ifid_en(o3[6]), .idex_en(o3[5]), .exmem_en(o3[4]),
    .ifid_flush(o3[3]), .idex_bubble(o3[2]), .memwb_bubble(o3[1]), .irq_take(o3[0])
`ifdef HAZARD_PERF_EN
    , .stall_cycles(sc[2]), .flush_count(fc[2])
`endif
  );

  // Model: remaining load-use bubbles, pending memory release, irq lock-out.
  int          stall_left [3] = '{0, 0, 0};
  bit          waiting    [3] = '{0, 0, 0};
  bit          irq_block  [3] = '{0, 0, 0};
  int unsigned stall_m    [3] = '{0, 0, 0};
  int unsigned flush_m    [3] = '{0, 0, 0};

  function automatic bit load_use();
    return ex_memread && (ex_rc != 5'd31) &&
           ((ex_rc == id_ra) || (id_uses_rb && (ex_rc == id_rb)));
  endfunction

  function automatic logic [7:0] model_out(int i);
    if (!reset)                                  return 8'hFE;
    if (mem_req && !mem_ready)                   return 8'h02;
    if (waiting[i])                              return 8'h00;
    if (ex_branch_taken)                         return 8'hFC;
    if ((stall_left[i] > 0) || load_use())       return 8'h34;
    if (irq && !kernel_mode && !irq_block[i])    return 8'hF9;
    return 8'hF0;
  endfunction

  function automatic logic [7:0] dut_out(int i);
    case (i)
      0:       return o1;
      1:       return o2;
      default: return o3;
    endcase
  endfunction

  task automatic check8(string nm, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model to the next edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        logic [7:0] e;
        e = model_out(i);
        check8($sformatf("model_L%0d", i + 1), dut_out(i), e);
`ifdef HAZARD_PERF_EN
        check8($sformatf("stall_cycles_L%0d", i + 1), sc[i][7:0], 8'(stall_m[i]));
        check8($sformatf("flush_count_L%0d", i + 1), fc[i][7:0], 8'(flush_m[i]));
        if (!reset) begin
          stall_m[i] = 0;
          flush_m[i] = 0;
        end else begin
          if (!e[7]) stall_m[i]++;
          if (e[3])  flush_m[i]++;
        end
`endif
        if (!reset) begin
          stall_left[i] = 0;
          waiting[i]    = 1'b0;
          irq_block[i]  = 1'b0;
        end else if (mem_req && !mem_ready) begin
          waiting[i]   = 1'b1;
          irq_block[i] = 1'b0;
        end else if (waiting[i]) begin
          waiting[i] = 1'b0;
        end else if (ex_branch_taken) begin
          stall_left[i] = 0;
          irq_block[i]  = 1'b0;
        end else if (stall_left[i] > 0) begin
          stall_left[i]--;
        end else if (load_use()) begin
          stall_left[i] = i;
          irq_block[i]  = 1'b0;
        end else begin
          irq_block[i] = (e == 8'hF9);
        end
      end
    end
  end

  task automatic vec(string nm, bit a_rst, bit a_irq, bit a_km,
                     logic [4:0] a_ra, logic [4:0] a_rb, bit a_urb,
                     logic [4:0] a_rc, bit a_mr, bit a_br, bit a_mreq, bit a_mrdy,
                     logic [7:0] e1, logic [7:0] e2);
    reset           = a_rst;
    irq             = a_irq;
    kernel_mode     = a_km;
    id_ra           = a_ra;
    id_rb           = a_rb;
    id_uses_rb      = a_urb;
    ex_rc           = a_rc;
    ex_memread      = a_mr;
    ex_branch_taken = a_br;
    mem_req         = a_mreq;
    mem_ready       = a_mrdy;
    @(negedge clk);
    #1;
    check8({nm, "_L1"}, o1, e1);
    check8({nm, "_L2"}, o2, e2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //   name        rst irq km  ra     rb     urb rc     mr br mq mr   L1     L2
    vec("rst0",      0, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hFE, 8'hFE);
    vec("rst1",      0, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hFE, 8'hFE);
    vec("idle",      1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("lu_ra",     1, 0, 0, 5'd5,  5'd2,  1, 5'd5,  1, 0, 0, 0, 8'h34, 8'h34);
    vec("lu_tail1",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'h34);
    vec("lu_tail2",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("lu_tail3",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("r31",       1, 0, 0, 5'd31, 5'd31, 1, 5'd31, 1, 0, 0, 0, 8'hF0, 8'hF0);
    vec("rb_unused", 1, 0, 0, 5'd1,  5'd5,  0, 5'd5,  1, 0, 0, 0, 8'hF0, 8'hF0);
    vec("lu_rb",     1, 0, 0, 5'd1,  5'd5,  1, 5'd5,  1, 0, 0, 0, 8'h34, 8'h34);
    vec("wait0",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 1, 0, 8'h02, 8'h02);
    vec("wait1",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 1, 0, 8'h02, 8'h02);
    vec("wait2",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 1, 0, 8'h02, 8'h02);
    vec("ready",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 1, 1, 8'h00, 8'h00);
    vec("flush",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 0, 0, 8'hFC, 8'hFC);
    vec("br_lu",     1, 0, 0, 5'd5,  5'd2,  1, 5'd5,  1, 1, 0, 0, 8'hFC, 8'hFC);
    vec("idle2",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("fz_lu",     1, 0, 0, 5'd7,  5'd2,  1, 5'd7,  1, 0, 0, 0, 8'h34, 8'h34);
    vec("fz_wait",   1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 1, 0, 8'h02, 8'h02);
    vec("fz_ready",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 1, 1, 8'h00, 8'h00);
    vec("fz_tail1",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'h34);
    vec("fz_tail2",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("irq_take",  1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF9, 8'hF9);
    vec("irq_hold",  1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("irq_again", 1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF9, 8'hF9);
    vec("irq_km0",   1, 1, 1, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("irq_km1",   1, 1, 1, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("irq_lu",    1, 1, 0, 5'd5,  5'd2,  1, 5'd5,  1, 0, 0, 0, 8'h34, 8'h34);
    vec("irq_stall", 1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF9, 8'h34);
    vec("irq_off",   1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("rs_lu",     1, 0, 0, 5'd9,  5'd2,  1, 5'd9,  1, 0, 0, 0, 8'h34, 8'h34);
    vec("rs_stall",  0, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hFE, 8'hFE);
    vec("rs_after",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("rw_wait",   1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 1, 0, 8'h02, 8'h02);
    vec("rw_reset",  0, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 1, 0, 8'hFE, 8'hFE);
    vec("rw_after",  1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    vec("irq_br",    1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 1, 0, 0, 8'hFC, 8'hFC);
    vec("irq_post",  1, 1, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF9, 8'hF9);
    vec("idle3",     1, 0, 0, 5'd1,  5'd2,  1, 5'd3,  0, 0, 0, 0, 8'hF0, 8'hF0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/beta_hazard_ctrl.md
# beta_hazard_ctrl

Pipeline hazard and stall controller for the pipelined Beta core. It watches the decode, execute and memory stages. It drives the enable, bubble and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, waits on multi-cycle memory, squashes instructions on taken branches and sequences interrupt entry.

## Interface
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1 with MEM→EX forwarding, 2 without); legal 1..3
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- irq  in  1  level interrupt request
- kernel_mode  in  1  supervisor bit of the current PC; masks irq when 1
- id_ra, id_rb  in  5  source register fields of the instruction in ID
- id_uses_rb  in  1  instruction in ID reads rb
- ex_rc  in  5  destination register of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_req, mem_ready  in  1 each  MEM-stage access outstanding / data memory done
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables
- ifid_flush, idex_bubble, memwb_bubble  out  1 each  load NOP into that register
- irq_take  out  1  select the interrupt vector into PC and save XP
- stall_cycles, flush_count  out  32 each  (HAZARD_PERF_EN only)

## Operation
- FSM states: RUN, LD_STALL, MEM_WAIT, IRQ_HOLD.
- Outputs are Mealy: combinational from state and current inputs.
- Priority when events coincide: memory wait > branch flush > load-use > irq.
- Memory wait (mem_req && !mem_ready) in any state:
  - All four enables = 0 and memwb_bubble = 1; go to MEM_WAIT.
  - Leave MEM_WAIT to the saved return state (RUN or LD_STALL) in the cycle after mem_ready.
  - The LD_STALL countdown is frozen while in MEM_WAIT.
  - A held ex_branch_taken takes effect only after the wait ends.
- Branch flush (ex_branch_taken): ifid_flush = 1 and idex_bubble = 1; pc_en stays 1; load-use check suppressed; irq not taken.
- Load-use hazard: ex_memread && ex_rc != 31 && (ex_rc == id_ra || (id_uses_rb && ex_rc == id_rb)).
  - R31 never creates a hazard.
  - In the detection cycle: pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - If LOAD_STALL_CYCLES > 1: go to LD_STALL and repeat the same outputs for LOAD_STALL_CYCLES−1 further cycles via a down-counter, then return to RUN.
- Irq: taken when irq && !kernel_mode in RUN with no wait, flush or hazard.
  - irq_take = 1 and ifid_flush = 1 for one cycle; go to IRQ_HOLD.
  - IRQ_HOLD lasts 1 cycle, ignores irq and returns to RUN, allowing time for kernel_mode to propagate.
- Reset (reset = 0, sampled at posedge):
  - Next state RUN; counter and perf registers cleared.
  - While reset is low: all enables 1; ifid_flush, idex_bubble and memwb_bubble = 1; irq_take = 0.
  - Reset asserted mid-stall or mid-wait aborts the stall or wait immediately.

## Timing
- Zero-cycle latency from hazard inputs to controls; paths are combinational, so no registered outputs.
- State, counter and perf registers update on posedge clk only.
- A load-use hazard costs exactly LOAD_STALL_CYCLES cycles of pc_en = 0, plus any memory-wait cycles.
- irq_take is a single-cycle pulse; minimum spacing between pulses is 2 cycles.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments each cycle with pc_en = 0 and reset high.
  - flush_count increments on each branch flush or irq_take.
  - Both are 32-bit and wrap to 0.
- HAZARD_PERF_EN undefined: both ports and their registers are absent; all other behaviour is identical.

## Structure
- Package beta_hazard_pkg holds:
  - state enum hazard_state_t
  - REG_ZERO = 5'd31
  - the LOAD_STALL_CYCLES legal-range constants
- Sub-module load_use_detect: the purely combinational hazard comparator.

## Test plan
- Reset: hold reset = 0 for 2 cycles → ifid_flush = idex_bubble = memwb_bubble = 1 and pc_en = 1; release → all bubbles 0, no stall.
- Load-use: ex_memread = 1, ex_rc = 5, id_ra = 5 → one cycle of pc_en = 0, ifid_en = 0, idex_bubble = 1. Repeat with LOAD_STALL_CYCLES = 2 → two cycles. Repeat with ex_rc = id_ra = 31 → no stall.
- Unused rb: id_uses_rb = 0, id_rb = 5 = ex_rc, ex_memread = 1 → no stall.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles with ex_branch_taken = 1 → all enables 0 and memwb_bubble = 1 for 3 cycles with no flush; ready arrives → flush asserted next.
- Branch plus load-use in the same cycle → ifid_flush = idex_bubble = 1 and pc_en = 1; flush_count = 1.
- Irq: irq = 1, kernel_mode = 0 in RUN → irq_take pulse for 1 cycle; following cycle irq still 1 → irq_take = 0. kernel_mode = 1 → never taken.
